// File: rtl/lsu_defs.sv
// Shared definitions for the load/store initiator.
//   - RV32 funct3 width/sign encodings (shared by loads and stores).
//   - FSM state encoding for lsu_mem_initiator.
//   - f3_legal: which funct3 values are accepted for a load or a store.
package lsu_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
  function automatic logic f3_legal(input logic is_write, input logic [2:0] f3);
    if (is_write) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store initiator.
// Ports:
//   funct3     in   RV32 funct3 of the access
//   addr_lo    in   byte address bits [1:0]
//   old_word   in   current memory word (read side)
//   store_data in   core store data
//   store_word out  old_word with the addressed lane replaced (full word for SW)
//   load_value out  addressed lane, sign/zero-extended to 32 bits
//   misaligned out  halfword with addr[0] set, or word with addr[1:0] nonzero
// Lane selection always truncates to natural alignment; whether misalignment
// is an error is decided by the caller.
module lsu_align
  import lsu_defs::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] store_word,
  output logic [31:0] load_value,
  output logic        misaligned
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = old_word[{addr_lo, 3'b000} +: 8];
    ld_half = old_word[{addr_lo[1], 4'b0000} +: 16];

    store_word = old_word;
    load_value = '0;
    misaligned = 1'b0;

    case (funct3)
      F3_B: begin
        store_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
        load_value = {{24{ld_byte[7]}}, ld_byte};
      end
      F3_H: begin
        store_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
        load_value = {{16{ld_half[15]}}, ld_half};
        misaligned = addr_lo[0];
      end
      F3_W: begin
        store_word = store_data;
        load_value = old_word;
        misaligned = |addr_lo;
      end
      F3_BU: load_value = {24'h0, ld_byte};
      F3_HU: begin
        load_value = {16'h0, ld_half};
        misaligned = addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the RV32 execute stage and a word-addressed
// data memory with combinational read.  One request per 3 cycles:
// accept (IDLE) -> ACCESS (memory read / write strobe) -> RESP (result pulse).
// Sub-word stores read-merge-write the whole word inside ACCESS.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_write, req_funct3      store/load select, RV32 funct3
//   req_addr, req_wdata        byte address, store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       load result (0 for stores), illegal/misaligned
//   mem_addr                   word index {2'b00, addr[N-1:2]}
//   mem_write_enable/_data     write strobe and full word
//   mem_read_data              combinational read of mem_addr
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into
// errors (no write, rdata 0); otherwise low address bits are truncated.
module lsu_mem_initiator
  import lsu_defs::*;
#(
  parameter int N           = 32,
  parameter int WORD_ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [2:0]   req_funct3,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic [N-1:0] mem_addr,
  output logic         mem_write_enable,
  output logic [N-1:0] mem_write_data,
  input  logic [N-1:0] mem_read_data
);

  lsu_state_e state, state_nx;

  logic         write_q;
  logic [2:0]   f3_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;

  logic [N-1:0] store_word;
  logic [N-1:0] load_value;
  logic         misaligned;
  logic         legal;
  logic         trap;
  logic         do_write;

  // Addresses beyond the memory alias silently; this flag is informational.
  logic         addr_aliased_unused;

  lsu_align u_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .old_word   (mem_read_data),
    .store_data (wdata_q),
    .store_word (store_word),
    .load_value (load_value),
    .misaligned (misaligned)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap                = misaligned;
  assign addr_aliased_unused = |addr_q[N-1:WORD_ADDR_W+2];
`else
  assign trap                = 1'b0;
  assign addr_aliased_unused = (|addr_q[N-1:WORD_ADDR_W+2]) | misaligned;
`endif

  assign legal    = f3_legal(write_q, f3_q);
  assign do_write = write_q & legal & ~trap;
  assign mem_addr = {2'b00, addr_q[N-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Write strobe is decoded from the state register, so an async reset
  // during ACCESS removes it immediately.
  always_comb begin
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    case (state)
      IDLE:   req_ready = 1'b1;
      ACCESS: begin
        mem_write_enable = do_write;
        mem_write_data   = do_write ? store_word : '0;
      end
      RESP:   resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q    <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        write_q <= req_write;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == ACCESS) begin
        resp_rdata <= (!write_q && legal && !trap) ? load_value : '0;
        resp_err   <= ~legal | trap;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  lsu_mem_initiator #(.N(32), .WORD_ADDR_W(10)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  // Responder memory: 1024 words, aliases modulo 4 KB.
  logic [31:0] tb_mem [0:1023];
  assign mem_read_data = tb_mem[mem_addr[9:0]];

  int          cyc = 0;
  int          acc_q[$];
  int          we_count = 0;
  logic [31:0] last_we_addr = '0;

  always @(posedge clk) begin
    cyc++;
    if (req_valid && req_ready) acc_q.push_back(cyc);
    if (mem_write_enable === 1'b1) begin
      we_count++;
      last_we_addr = mem_addr;
      tb_mem[mem_addr[9:0]] <= mem_write_data;
    end
  end

  // Reference model: byte-addressed 4 KB memory with RV32 access rules.
  logic [7:0] ref_mem [0:4095];

  task automatic model_req(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd,
                           output logic err, output bit wrote);
    bit legal, trap;
    int unsigned w, base;
    logic [31:0] v;
    legal = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
    w = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = legal && ((addr % w) != 0);
`else
    trap = 1'b0;
`endif
    err = !legal || trap;
    rd = '0;
    wrote = 1'b0;
    if (err) return;
    base = ((addr / w) * w) % 4096;
    if (wr) begin
      for (int i = 0; i < int'(w); i++) ref_mem[base + i] = wdata[8*i +: 8];
      wrote = 1'b1;
    end else begin
      v = '0;
      for (int i = 0; i < int'(w); i++) v = v | (32'(ref_mem[base + i]) << (8*i));
      if (!f3[2] && w < 4 && v[8*w-1]) v = v | (32'hFFFF_FFFF << (8*w));
      rd = v;
    end
  endtask

  // Runs one request through the DUT; lat = cycles from accept to resp_valid.
  task automatic txn(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                     output int lat, output int nw, output logic [31:0] waddr,
                     output logic tail);
    int w0, k;
    @(posedge clk); #1;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    w0 = we_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata; err = resp_err;
    @(posedge clk); #1;
    tail = resp_valid;
    nw = we_count - w0;
    waddr = last_we_addr;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write_enable, mem_write_data}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b rv=%b rd=%h err=%b ma=%h we=%b wd=%h want 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write_enable, mem_write_data);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_store_word;
    logic [31:0] rd, waddr, mrd; logic err, tail, merr; int lat, nw; bit wrote;
    model_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, mrd, merr, wrote);
    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, err, lat, nw, waddr, tail);
    checks++;
    if (nw !== 1 || waddr !== 32'h4) begin
      errors++; $display("FAIL sw_strobe got writes=%0d addr=%h want 1 00000004", nw, waddr);
    end
    checks++;
    if (lat !== 2 || tail !== 1'b0) begin
      errors++; $display("FAIL sw_latency got lat=%0d tail=%b want 2 0", lat, tail);
    end
    checks++;
    if ({err, rd} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL sw_resp got err=%b rd=%h want 0 00000000", err, rd);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ads [5] = '{32'h10, 32'h13, 32'h13, 32'h10, 32'h12};
    logic [31:0] exp [5] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    logic [31:0] rd, waddr, mrd; logic err, tail, merr; int lat, nw; bit wrote;
    for (int i = 0; i < 5; i++) begin
      model_req(1'b0, f3s[i], ads[i], 32'h0, mrd, merr, wrote);
      txn(1'b0, f3s[i], ads[i], 32'h0, rd, err, lat, nw, waddr, tail);
      checks++;
      if ({err, rd} !== {1'b0, exp[i]}) begin
        errors++; $display("FAIL load_%0d got err=%b rd=%h want 0 %h", i, err, rd, exp[i]);
      end
      checks++;
      if (lat !== 2 || nw !== 0) begin
        errors++; $display("FAIL load_%0d_timing got lat=%0d writes=%0d want 2 0", i, lat, nw);
      end
    end
  endtask

  task automatic test_subword_store;
    logic [31:0] rd, waddr, mrd; logic err, tail, merr; int lat, nw; bit wrote;
    model_req(1'b1, 3'b001, 32'h12, 32'hAAAA1234, mrd, merr, wrote);
    txn(1'b1, 3'b001, 32'h12, 32'hAAAA1234, rd, err, lat, nw, waddr, tail);
    checks++;
    if (tb_mem[4] !== 32'h1234BEEF || nw !== 1) begin
      errors++; $display("FAIL sh_merge got %h writes=%0d want 1234beef 1", tb_mem[4], nw);
    end
    model_req(1'b1, 3'b000, 32'h10, 32'h00000077, mrd, merr, wrote);
    txn(1'b1, 3'b000, 32'h10, 32'h00000077, rd, err, lat, nw, waddr, tail);
    checks++;
    if (tb_mem[4] !== 32'h1234BE77 || nw !== 1) begin
      errors++; $display("FAIL sb_merge got %h writes=%0d want 1234be77 1", tb_mem[4], nw);
    end
  endtask

  task automatic test_illegal;
    bit          wrs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0]  f3s [6] = '{3'b011, 3'b110, 3'b111, 3'b011, 3'b100, 3'b111};
    logic [31:0] rd, waddr, mrd; logic err, tail, merr; int lat, nw; bit wrote;
    for (int i = 0; i < 6; i++) begin
      model_req(wrs[i], f3s[i], 32'h10, 32'h0BAD0BAD, mrd, merr, wrote);
      txn(wrs[i], f3s[i], 32'h10, 32'h0BAD0BAD, rd, err, lat, nw, waddr, tail);
      checks++;
      if ({err, rd} !== {1'b1, 32'h0} || nw !== 0 || lat !== 2) begin
        errors++;
        $display("FAIL illegal_%0d got err=%b rd=%h writes=%0d lat=%0d want 1 00000000 0 2",
                 i, err, rd, nw, lat);
      end
    end
  endtask

  task automatic test_misalign;
    logic [31:0] rd, waddr, mrd; logic err, tail, merr; int lat, nw; bit wrote;
    model_req(1'b0, 3'b010, 32'h11, 32'h0, mrd, merr, wrote);
    txn(1'b0, 3'b010, 32'h11, 32'h0, rd, err, lat, nw, waddr, tail);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if ({err, rd} !== {1'b1, 32'h0} || lat !== 2) begin
      errors++; $display("FAIL lw_misaligned got err=%b rd=%h lat=%0d want 1 00000000 2", err, rd, lat);
    end
    model_req(1'b1, 3'b010, 32'h11, 32'hCAFEF00D, mrd, merr, wrote);
    txn(1'b1, 3'b010, 32'h11, 32'hCAFEF00D, rd, err, lat, nw, waddr, tail);
    checks++;
    if (nw !== 0 || err !== 1'b1 || tb_mem[4] !== 32'h1234BE77) begin
      errors++; $display("FAIL sw_misaligned got writes=%0d err=%b word=%h want 0 1 1234be77",
                         nw, err, tb_mem[4]);
    end
`else
    checks++;
    if ({err, rd} !== {1'b0, 32'h1234BE77} || lat !== 2) begin
      errors++; $display("FAIL lw_misaligned got err=%b rd=%h lat=%0d want 0 1234be77 2", err, rd, lat);
    end
    model_req(1'b0, 3'b001, 32'h11, 32'h0, mrd, merr, wrote);
    txn(1'b0, 3'b001, 32'h11, 32'h0, rd, err, lat, nw, waddr, tail);
    checks++;
    if ({err, rd} !== {1'b0, 32'hFFFFBE77}) begin
      errors++; $display("FAIL lh_misaligned got err=%b rd=%h want 0 ffffbe77", err, rd);
    end
`endif
  endtask

  task automatic test_reset_mid_access;
    int w0;
    logic [31:0] rd, waddr, mrd; logic err, tail, merr; int lat, nw; bit wrote;
    @(posedge clk); #1;
    req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h55;
    req_valid = 1'b1;
    w0 = we_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_write_enable !== 1'b1 || mem_addr !== 32'h8) begin
      errors++; $display("FAIL rst_pre_we got we=%b addr=%h want 1 00000008", mem_write_enable, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write_enable !== 1'b0) begin
      errors++; $display("FAIL rst_we_drop got %b want 0", mem_write_enable);
    end
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_release got rdy=%b rv=%b want 1 0", req_ready, resp_valid);
    end
    checks++;
    if (tb_mem[8] !== 32'h0 || we_count !== w0) begin
      errors++; $display("FAIL rst_no_write got word=%h writes=%0d want 00000000 0", tb_mem[8], we_count - w0);
    end
    model_req(1'b0, 3'b010, 32'h20, 32'h0, mrd, merr, wrote);
    txn(1'b0, 3'b010, 32'h20, 32'h0, rd, err, lat, nw, waddr, tail);
    checks++;
    if ({err, rd} !== {merr, mrd} || lat !== 2) begin
      errors++; $display("FAIL rst_followup got err=%b rd=%h lat=%0d want %b %h 2", err, rd, lat, merr, mrd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, mrd, rd_b; logic merr; bit wrote; int k;
    d = $urandom;
    model_req(1'b1, 3'b010, 32'h40, d, mrd, merr, wrote);
    model_req(1'b0, 3'b010, 32'h40, 32'h0, mrd, merr, wrote);
    @(posedge clk); #1;
    acc_q.delete();
    req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = d;
    req_valid = 1'b1;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (resp_valid !== 1'b1 && k < 10);
    // Valid stays high through RESP; the second request must wait for IDLE.
    req_write = 1'b0; req_wdata = '0;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (resp_valid !== 1'b1 && k < 10);
    req_valid = 1'b0;
    rd_b = resp_rdata;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (acc_q.size() !== 2 || (acc_q.size() == 2 && acc_q[1] - acc_q[0] !== 3)) begin
      errors++;
      $display("FAIL b2b_spacing got accepts=%0d gap=%0d want 2 3", acc_q.size(),
               acc_q.size() >= 2 ? acc_q[1] - acc_q[0] : -1);
    end
    checks++;
    if (rd_b !== mrd) begin
      errors++; $display("FAIL b2b_data got %h want %h", rd_b, mrd);
    end
  endtask

  task automatic test_random;
    logic [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] rd, waddr, mrd, addr, wdata; logic err, tail, merr; int lat, nw; bit wrote, wr;
    logic [2:0]  f3;
    logic [31:0] word;
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = wr ? legal_f3[$urandom_range(0, 2)] : legal_f3[$urandom_range(0, 4)];
      addr  = $urandom & 32'hF000_F0FF;
      wdata = $urandom;
      model_req(wr, f3, addr, wdata, mrd, merr, wrote);
      txn(wr, f3, addr, wdata, rd, err, lat, nw, waddr, tail);
      checks++;
      if ({err, rd} !== {merr, mrd} || lat !== 2 || tail !== 1'b0) begin
        errors++;
        $display("FAIL rand_%0d resp got err=%b rd=%h lat=%0d want %b %h 2 (wr=%b f3=%0d addr=%h)",
                 i, err, rd, lat, merr, mrd, wr, f3, addr);
      end
      checks++;
      if (nw !== int'(wrote) || (wrote && waddr !== (addr >> 2))) begin
        errors++;
        $display("FAIL rand_%0d write got n=%0d addr=%h want %0d %h", i, nw, waddr, wrote, addr >> 2);
      end
    end
    for (int w = 0; w < 1024; w++) begin
      word = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
      checks++;
      if (tb_mem[w] !== word) begin
        errors++; $display("FAIL mem_word_%0d got %h want %h", w, tb_mem[w], word);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) tb_mem[i] = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    test_reset;
    test_store_word;
    test_loads;
    test_subword_store;
    test_illegal;
    test_misalign;
    test_reset_mid_access;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
